// File: rtl/common_pkg.sv
// Machine-wide widths shared by the pipeline blocks.
package common;
    localparam int MACHINE_WIDTH = 2;
    localparam int ALU_NUM       = 2;
endpackage

// File: rtl/rob_pkg.sv
// Reorder buffer types: default depth, index type and the per-entry record.
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_AW    = $clog2(ROB_DEPTH);

    typedef logic [ROB_AW-1:0] rob_addr_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        exc;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] pcplus8;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointers with a wrap bit, occupancy and free-space test for the reorder buffer.
module rob_ptr_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [$clog2(WIDTH+1)-1:0]     alloc_cnt,
    input  logic [$clog2(WIDTH+1)-1:0]     retire_cnt,
    input  logic                           flush,
    output logic [$clog2(DEPTH):0]         head_q,
    output logic [$clog2(DEPTH):0]         tail_q,
    output logic [$clog2(DEPTH):0]         occ,
    output logic                           alloc_room
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] DEPTH_V = AW1'(DEPTH);
    localparam logic [AW:0] WIDTH_V = AW1'(WIDTH);

    logic [AW:0] head_d, tail_d, free_cnt;

    // Wrap bit makes tail - head the true occupancy, so full and empty are distinguishable.
    always_comb begin
        occ        = tail_q - head_q;
        free_cnt   = DEPTH_V - occ;
        alloc_room = (free_cnt >= WIDTH_V);
        head_d     = flush ? '0 : head_q + AW1'(retire_cnt);
        tail_d     = flush ? '0 : tail_q + AW1'(alloc_cnt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire, flush on head exception.
// Define REORDER_BUFFER_OCCUPANCY_EN to add the registered occupancy output.
module reorder_buffer #(
    parameter int ROB_DEPTH     = rob_pkg::ROB_DEPTH,
    parameter int MACHINE_WIDTH = common::MACHINE_WIDTH,
    parameter int ALU_NUM       = common::ALU_NUM
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic [MACHINE_WIDTH-1:0]                    alloc_valid,
    input  logic [MACHINE_WIDTH*5-1:0]                  alloc_dst,
    input  logic [MACHINE_WIDTH*32-1:0]                 alloc_pcplus8,
    output logic                                        alloc_ready,
    output logic [MACHINE_WIDTH*$clog2(ROB_DEPTH)-1:0]  rob_addr_new,
    input  logic [ALU_NUM-1:0]                          wb_valid,
    input  logic [ALU_NUM*$clog2(ROB_DEPTH)-1:0]        wb_rob_addr,
    input  logic [ALU_NUM*32-1:0]                       wb_data,
    input  logic [ALU_NUM-1:0]                          wb_exc,
    output logic [MACHINE_WIDTH-1:0]                    retire_valid,
    output logic [MACHINE_WIDTH*5-1:0]                  retire_dst,
    output logic [MACHINE_WIDTH*32-1:0]                 retire_data,
    output logic [MACHINE_WIDTH*32-1:0]                 retire_pcplus8,
`ifdef REORDER_BUFFER_OCCUPANCY_EN
    output logic [$clog2(ROB_DEPTH):0]                  occupancy,
`endif
    output logic                                        flush,
    output logic [31:0]                                 flush_pcplus8
);
    localparam int AW  = $clog2(ROB_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(MACHINE_WIDTH + 1);

    typedef rob_pkg::rob_entry_t entry_t;

    logic [AW:0]              head_q, tail_q, occ;
    logic                     alloc_room;
    logic [CW-1:0]            alloc_cnt, retire_cnt;
    logic [MACHINE_WIDTH-1:0] alloc_fire, retire_ok;
    logic [AW-1:0]            head_idx [MACHINE_WIDTH];
    logic [AW-1:0]            tail_idx [MACHINE_WIDTH];
    entry_t                   entry_q  [ROB_DEPTH];
    entry_t                   entry_d  [ROB_DEPTH];
    entry_t                   head_entry;

    rob_ptr_ctrl #(
        .DEPTH (ROB_DEPTH),
        .WIDTH (MACHINE_WIDTH)
    ) u_ptr (
        .clk        (clk),
        .resetn     (resetn),
        .alloc_cnt  (alloc_cnt),
        .retire_cnt (retire_cnt),
        .flush      (flush),
        .head_q     (head_q),
        .tail_q     (tail_q),
        .occ        (occ),
        .alloc_room (alloc_room)
    );

`ifdef REORDER_BUFFER_OCCUPANCY_EN
    assign occupancy = occ;
`endif

    assign head_entry    = entry_q[head_q[AW-1:0]];
    assign flush         = head_entry.valid & head_entry.done & head_entry.exc;
    assign flush_pcplus8 = flush ? head_entry.pcplus8 : '0;
    assign alloc_ready   = alloc_room & ~flush;

    generate
        for (genvar gi = 0; gi < MACHINE_WIDTH; gi++) begin : g_slot
            assign head_idx[gi]                = head_q[AW-1:0] + AW'(gi);
            assign tail_idx[gi]                = tail_q[AW-1:0] + AW'(gi);
            assign rob_addr_new[gi*AW +: AW]   = tail_idx[gi];
            assign retire_valid[gi]            = retire_ok[gi];
            assign retire_dst[gi*5 +: 5]       = retire_ok[gi] ? entry_q[head_idx[gi]].dst     : '0;
            assign retire_data[gi*32 +: 32]    = retire_ok[gi] ? entry_q[head_idx[gi]].data    : '0;
            assign retire_pcplus8[gi*32 +: 32] = retire_ok[gi] ? entry_q[head_idx[gi]].pcplus8 : '0;
        end
    endgenerate

    // Both chains stop at the first slot that cannot proceed, keeping retirement in order.
    always_comb begin
        logic r_chain;
        logic a_chain;
        retire_ok  = '0;
        retire_cnt = '0;
        alloc_fire = '0;
        alloc_cnt  = '0;
        r_chain    = ~flush;
        a_chain    = alloc_ready;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (r_chain && (AW1'(i) < occ) && entry_q[head_idx[i]].valid &&
                entry_q[head_idx[i]].done && !entry_q[head_idx[i]].exc) begin
                retire_ok[i] = 1'b1;
                retire_cnt   = retire_cnt + CW'(1);
            end else begin
                r_chain = 1'b0;
            end
            if (a_chain && alloc_valid[i]) begin
                alloc_fire[i] = 1'b1;
                alloc_cnt     = alloc_cnt + CW'(1);
            end else begin
                a_chain = 1'b0;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < ROB_DEPTH; j++) begin
            entry_d[j] = entry_q[j];
        end
        // Later ports overwrite earlier ones when they target the same entry.
        for (int k = 0; k < ALU_NUM; k++) begin
            if (wb_valid[k] && entry_q[wb_rob_addr[k*AW +: AW]].valid) begin
                entry_d[wb_rob_addr[k*AW +: AW]].done = 1'b1;
                entry_d[wb_rob_addr[k*AW +: AW]].data = wb_data[k*32 +: 32];
                entry_d[wb_rob_addr[k*AW +: AW]].exc  = wb_exc[k];
            end
        end
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (retire_ok[i]) begin
                entry_d[head_idx[i]].valid = 1'b0;
                entry_d[head_idx[i]].done  = 1'b0;
            end
        end
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (alloc_fire[i]) begin
                entry_d[tail_idx[i]].valid   = 1'b1;
                entry_d[tail_idx[i]].done    = 1'b0;
                entry_d[tail_idx[i]].exc     = 1'b0;
                entry_d[tail_idx[i]].dst     = alloc_dst[i*5 +: 5];
                entry_d[tail_idx[i]].data    = '0;
                entry_d[tail_idx[i]].pcplus8 = alloc_pcplus8[i*32 +: 32];
            end
        end
        if (flush) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                entry_d[j].valid = 1'b0;
                entry_d[j].done  = 1'b0;
                entry_d[j].exc   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                entry_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                entry_q[j] <= entry_d[j];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer: stimulus queues expected retirements/flushes, a monitor pops them.
module tb_reorder_buffer;
    localparam int D  = 16;
    localparam int MW = 2;
    localparam int AN = 2;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [MW-1:0]     alloc_valid;
    logic [MW*5-1:0]   alloc_dst;
    logic [MW*32-1:0]  alloc_pcplus8;
    logic              alloc_ready;
    logic [MW*AW-1:0]  rob_addr_new;
    logic [AN-1:0]     wb_valid;
    logic [AN*AW-1:0]  wb_rob_addr;
    logic [AN*32-1:0]  wb_data;
    logic [AN-1:0]     wb_exc;
    logic [MW-1:0]     retire_valid;
    logic [MW*5-1:0]   retire_dst;
    logic [MW*32-1:0]  retire_data;
    logic [MW*32-1:0]  retire_pcplus8;
    logic              flush;
    logic [31:0]       flush_pcplus8;
`ifdef REORDER_BUFFER_OCCUPANCY_EN
    logic [AW:0]       occupancy;
`endif

    typedef struct {
        bit          is_flush;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_DEPTH(D), .MACHINE_WIDTH(MW), .ALU_NUM(AN)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .alloc_valid    (alloc_valid),
        .alloc_dst      (alloc_dst),
        .alloc_pcplus8  (alloc_pcplus8),
        .alloc_ready    (alloc_ready),
        .rob_addr_new   (rob_addr_new),
        .wb_valid       (wb_valid),
        .wb_rob_addr    (wb_rob_addr),
        .wb_data        (wb_data),
        .wb_exc         (wb_exc),
        .retire_valid   (retire_valid),
        .retire_dst     (retire_dst),
        .retire_data    (retire_data),
        .retire_pcplus8 (retire_pcplus8),
`ifdef REORDER_BUFFER_OCCUPANCY_EN
        .occupancy      (occupancy),
`endif
        .flush          (flush),
        .flush_pcplus8  (flush_pcplus8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid = '0;
        wb_valid    = '0;
        wb_exc      = '0;
    endtask

    task automatic alloc(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                         input logic [31:0] p0, input logic [31:0] p1);
        alloc_valid   = v;
        alloc_dst     = {d1, d0};
        alloc_pcplus8 = {p1, p0};
    endtask

    task automatic wb(input int port, input logic [3:0] a, input logic [31:0] d, input logic e);
        wb_valid[port]              = 1'b1;
        wb_rob_addr[port*AW +: AW]  = a;
        wb_data[port*32 +: 32]      = d;
        wb_exc[port]                = e;
    endtask

    task automatic exp_ret(input logic [4:0] d, input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        e.is_flush = 1'b0; e.dst = d; e.data = data; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic exp_flush(input logic [31:0] pc);
        exp_t e;
        e.is_flush = 1'b1; e.dst = '0; e.data = '0; e.pc = pc;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per presented retirement slot or flush.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (flush) begin
                    chk("flush_blocks_retire", 64'(retire_valid), 64'd0);
                    if (sb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_flush: got pc %08h expected no flush", flush_pcplus8);
                    end else begin
                        e = sb.pop_front();
                        $display("flush pc %08h", flush_pcplus8);
                        chk("flush_kind", 64'(e.is_flush), 64'd1);
                        chk("flush_pcplus8", 64'(flush_pcplus8), 64'(e.pc));
                    end
                end
                for (int i = 0; i < MW; i++) begin
                    if (retire_valid[i]) begin
                        if (sb.size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL unexpected_retire: slot %0d got data %08h expected none", i, retire_data[i*32 +: 32]);
                        end else begin
                            e = sb.pop_front();
                            $display("retire slot %0d dst %0d data %08h pc %08h", i,
                                     retire_dst[i*5 +: 5], retire_data[i*32 +: 32], retire_pcplus8[i*32 +: 32]);
                            chk("retire_kind", 64'(e.is_flush), 64'd0);
                            chk("retire_dst", 64'(retire_dst[i*5 +: 5]), 64'(e.dst));
                            chk("retire_data", 64'(retire_data[i*32 +: 32]), 64'(e.data));
                            chk("retire_pcplus8", 64'(retire_pcplus8[i*32 +: 32]), 64'(e.pc));
                        end
                    end
                end
            end
        end
    end

    initial begin
        alloc_valid = '0; alloc_dst = '0; alloc_pcplus8 = '0;
        wb_valid = '0; wb_rob_addr = '0; wb_data = '0; wb_exc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_rob_addr_new", 64'(rob_addr_new), 64'h10);
        chk("rst_retire_data", 64'(retire_data), 64'd0);
        resetn = 1'b1;

        // First pair allocation and out-of-order completion
        chk("A_addr_pre", 64'(rob_addr_new), 64'h10);
        alloc(2'b11, 5'd3, 5'd4, 32'h100, 32'h104);
        tick();
        chk("A_addr_post", 64'(rob_addr_new), 64'h32);
`ifdef REORDER_BUFFER_OCCUPANCY_EN
        chk("A_occupancy", 64'(occupancy), 64'd2);
`endif
        wb(0, 4'd1, 32'hA, 1'b0);
        tick();
        chk("A_wait_partial", 64'(retire_valid), 64'd0);
        wb(0, 4'd0, 32'hB, 1'b0);
        exp_ret(5'd3, 32'hB, 32'h100);
        exp_ret(5'd4, 32'hA, 32'h104);
        tick();
        chk("A_retire_pair", 64'(retire_valid), 64'h3);
        tick();
        chk("A_after_retire", 64'(retire_valid), 64'd0);
        chk("A_tail", 64'(rob_addr_new), 64'h32);

        // Same-entry writeback priority and writeback to an unallocated entry
        alloc(2'b11, 5'd5, 5'd6, 32'h200, 32'h204);
        tick();
        wb(0, 4'd2, 32'h11, 1'b0);
        wb(1, 4'd2, 32'h22, 1'b0);
        exp_ret(5'd5, 32'h22, 32'h200);
        tick();
        chk("C_same_entry", 64'(retire_valid), 64'h1);
        tick();
        wb(0, 4'd7, 32'h77, 1'b1);
        tick();
        chk("C_wb_invalid_retire", 64'(retire_valid), 64'd0);
        chk("C_wb_invalid_flush", 64'(flush), 64'd0);
        chk("C_wb_invalid_addr", 64'(rob_addr_new), 64'h54);
        wb(1, 4'd3, 32'h33, 1'b0);
        exp_ret(5'd6, 32'h33, 32'h204);
        tick();
        chk("C_retire_e3", 64'(retire_valid), 64'h1);
        tick();

        // Exception at head flushes and discards that cycle's allocation
        alloc(2'b11, 5'd9, 5'd10, 32'hBFC00388, 32'hBFC0038C);
        tick();
        wb(0, 4'd4, 32'h99, 1'b1);
        wb(1, 4'd5, 32'h55, 1'b0);
        exp_flush(32'hBFC00388);
        tick();
        chk("F_flush", 64'(flush), 64'd1);
        chk("F_flush_pc", 64'(flush_pcplus8), 64'hBFC00388);
        chk("F_retire_blocked", 64'(retire_valid), 64'd0);
        chk("F_alloc_blocked", 64'(alloc_ready), 64'd0);
        alloc(2'b11, 5'd11, 5'd12, 32'h300, 32'h304);
        wb(0, 4'd5, 32'h66, 1'b0);
        tick();
        chk("F_after_flush", 64'(flush), 64'd0);
        chk("F_after_ready", 64'(alloc_ready), 64'd1);
        chk("F_after_addr", 64'(rob_addr_new), 64'h10);
        chk("F_after_retire", 64'(retire_valid), 64'd0);

        // Fill to 15 entries, hold, drain two, wrap the tail
        for (int j = 0; j < 7; j++) begin
            chk("B_fill_ready", 64'(alloc_ready), 64'd1);
            chk("B_fill_addr", 64'(rob_addr_new), 64'(((2*j+1) << 4) | (2*j)));
            alloc(2'b11, 5'(2*j+1), 5'(2*j+2), 32'h1000 + 32'(8*j), 32'h1004 + 32'(8*j));
            tick();
        end
        chk("B_single_ready", 64'(alloc_ready), 64'd1);
        alloc(2'b01, 5'd15, 5'd0, 32'h1038, 32'h0);
        tick();
        chk("B_15_ready", 64'(alloc_ready), 64'd0);
        chk("B_15_addr", 64'(rob_addr_new), 64'h0F);
        alloc(2'b11, 5'd20, 5'd21, 32'hDEAD0000, 32'hDEAD0004);
        tick();
        chk("B_held_addr", 64'(rob_addr_new), 64'h0F);
        chk("B_held_ready", 64'(alloc_ready), 64'd0);
`ifdef REORDER_BUFFER_OCCUPANCY_EN
        chk("B_occupancy", 64'(occupancy), 64'd15);
`endif
        wb(0, 4'd0, 32'h100, 1'b0);
        wb(1, 4'd1, 32'h101, 1'b0);
        exp_ret(5'd1, 32'h100, 32'h1000);
        exp_ret(5'd2, 32'h101, 32'h1004);
        tick();
        chk("B_retire01", 64'(retire_valid), 64'h3);
        tick();
        chk("B_ready_after_retire", 64'(alloc_ready), 64'd1);
        alloc(2'b11, 5'd16, 5'd17, 32'h2000, 32'h2004);
        wb(0, 4'd2, 32'h102, 1'b0);
        wb(1, 4'd3, 32'h103, 1'b0);
        exp_ret(5'd3, 32'h102, 32'h1008);
        exp_ret(5'd4, 32'h103, 32'h100C);
        tick();
        chk("B_tail_wrap", 64'(rob_addr_new), 64'h21);
        chk("B_wrap_ready", 64'(alloc_ready), 64'd0);
        chk("B_retire23", 64'(retire_valid), 64'h3);
        tick();
        alloc(2'b01, 5'd18, 5'd0, 32'h2008, 32'h0);
        tick();
        alloc(2'b11, 5'd19, 5'd20, 32'h200C, 32'h2010);
        tick();
        chk("B_full_ready", 64'(alloc_ready), 64'd0);
        chk("B_full_addr", 64'(rob_addr_new), 64'h54);
        wb(0, 4'd4, 32'h104, 1'b0);
        wb(1, 4'd5, 32'h105, 1'b0);
        exp_ret(5'd5, 32'h104, 32'h1010);
        exp_ret(5'd6, 32'h105, 32'h1014);
        tick();
        chk("B_retire_full", 64'(retire_valid), 64'h3);
        tick();
        chk("B_ready_after_full", 64'(alloc_ready), 64'd1);
        wb(0, 4'd6, 32'h106, 1'b0);
        exp_ret(5'd7, 32'h106, 32'h1018);
        tick();
        chk("B_retire6", 64'(retire_valid), 64'h1);
        alloc(2'b11, 5'd22, 5'd23, 32'h2014, 32'h2018);
        tick();
        chk("B_alloc_and_retire_addr", 64'(rob_addr_new), 64'h76);
        chk("B_alloc_and_retire_ready", 64'(alloc_ready), 64'd0);
        chk("B_alloc_and_retire_idle", 64'(retire_valid), 64'd0);

        // Reset with completed entries pending retirement
        wb(0, 4'd7, 32'h107, 1'b0);
        wb(1, 4'd8, 32'h108, 1'b0);
        tick();
        resetn = 1'b0;
        #1;
        chk("R_retire_valid", 64'(retire_valid), 64'd0);
        chk("R_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("R_flush", 64'(flush), 64'd0);
        chk("R_addr", 64'(rob_addr_new), 64'h10);
        chk("R_retire_data", 64'(retire_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("R_no_retire_after", 64'(retire_valid), 64'd0);
        end
        chk("R_addr_after", 64'(rob_addr_new), 64'h10);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, entry count (power of two, >= 4).
REQ-002 SHALL have parameter MACHINE_WIDTH, default 2, allocate/retire slots per cycle.
REQ-003 SHALL have parameter ALU_NUM, default 2, writeback ports.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports alloc_valid, alloc_dst, alloc_pcplus8  in  MACHINE_WIDTH / MACHINE_WIDTH x 5 / MACHINE_WIDTH x 32  allocation requests from renaming.
REQ-007 SHALL have ports alloc_ready, rob_addr_new  out  1 / MACHINE_WIDTH x log2(ROB_DEPTH)  capacity flag and the allocated indices.
REQ-008 SHALL have ports wb_valid, wb_rob_addr, wb_data, wb_exc  in  ALU_NUM / ALU_NUM x log2(ROB_DEPTH) / ALU_NUM x 32 / ALU_NUM  completion writebacks.
REQ-009 SHALL have ports retire_valid, retire_dst, retire_data, retire_pcplus8  out  MACHINE_WIDTH / x5 / x32 / x32  in-order retirement to RAT/ARF.
REQ-010 SHALL have ports flush, flush_pcplus8  out  1 / 32  exception at head.

Function
REQ-011 SHALL be a circular buffer; head/tail pointers log2(ROB_DEPTH)+1 bits (wrap bit); full = equal index, different wrap bit; empty = pointers equal.
REQ-012 SHALL drive alloc_ready = 1 iff free entries >= MACHINE_WIDTH and flush = 0 (combinational from registered state).
REQ-013 SHALL drive rob_addr_new[i] = tail index + i, wrapping modulo ROB_DEPTH, combinationally.
REQ-014 SHALL require alloc_valid contiguous from slot 0; allocate popcount(alloc_valid) entries when alloc_ready = 1; set entry valid, done = 0, exc = 0; tail advances next cycle.
REQ-015 SHALL ignore allocation when alloc_ready = 0; no state change.
REQ-016 SHALL, on wb_valid[k], set done and store data/exc at wb_rob_addr[k] on the next edge; writeback to an invalid entry SHALL be ignored; two ports to the same entry: higher k wins.
REQ-017 SHALL retire slot 0 when head entry valid, done, exc = 0; slot i > 0 only if slot i-1 retires and entry head+i satisfies the same; head advances by retired count.
REQ-018 SHALL retire from registered done only; an entry written back this cycle retires no earlier than next cycle (latency: writeback edge -> retire_valid one cycle later).
REQ-019 SHALL assert flush combinationally when head entry valid, done, exc = 1; flush_pcplus8 = that entry's pcplus8; retire_valid = 0 that cycle.
REQ-020 SHALL, at the edge ending a flush cycle, clear all valid bits and reset head = tail = 0; allocations and writebacks of that cycle discarded.
REQ-021 SHALL drive retire_valid = 0 when empty; simultaneous allocation and retirement in one cycle SHALL both take effect, including when full.

Reset
REQ-022 SHALL, while resetn = 0, clear head, tail, all valid/done/exc bits; outputs: alloc_ready = 1, retire_valid = 0, flush = 0, rob_addr_new = {MACHINE_WIDTH-1..0}, data outputs 0.
REQ-023 SHALL abandon all in-flight entries on reset mid-operation; first edge after deassertion behaves as empty.

Configuration
REQ-024 SHALL, with REORDER_BUFFER_OCCUPANCY_EN defined, add output occupancy (log2(ROB_DEPTH)+1 bits) = registered tail - head; without it the port and logic SHALL not exist and behaviour is otherwise identical.

Structure
REQ-025 SHALL take rob_addr_t, rob_entry_t (valid, done, exc, dst, data, pcplus8) and ROB_DEPTH from rob_pkg; MACHINE_WIDTH/ALU_NUM from common.
REQ-026 SHALL implement head/tail/free-count arithmetic in one sub-module, rob_ptr_ctrl; entry storage stays in reorder_buffer.

Verification
REQ-027 Reset, alloc 2 (dst 3,4) -> rob_addr_new = 0,1; next cycle rob_addr_new = 2,3, occupancy 2.
REQ-028 Writeback entry 1 then entry 0 (data 0xA, 0xB) -> nothing retires until both done; then retire_valid = 2'b11 in one cycle with data 0xB, 0xA in order.
REQ-029 Allocate to 15 entries -> alloc_ready = 0; allocation held, no pointer change; retire 2 -> alloc_ready = 1 next cycle, tail wraps to index 1 after next alloc pair.
REQ-030 Entry 0 writeback with wb_exc = 1, pcplus8 0xBFC00388 -> flush = 1, flush_pcplus8 = 0xBFC00388, retire_valid = 0; next cycle empty, alloc_ready = 1, rob_addr_new = 0,1.
REQ-031 Both wb ports to entry 2 same cycle (0x11, 0x22) -> retire_data = 0x22; wb to unallocated entry 7 -> no retirement, state unchanged.
REQ-032 resetn low mid-stream with 6 entries valid -> all outputs at reset values immediately, no retirements after release.
